// File: rtl/ppu_result_buffer.sv
// Result FIFO behind the PPU with an issue-credit counter that bounds in-flight work.
// Optional fall-through path for an empty FIFO: define PPU_RESBUF_BYPASS_EN.
module ppu_result_buffer #(
  parameter int WORD  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic                       ppu_valid_i,
  input  logic [WORD-1:0]            ppu_result_i,
  output logic                       out_valid_o,
  output logic [WORD-1:0]            out_data_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WORD-1:0] mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic            overflow_q, overflow_d;

  logic empty, full;
  logic bypass_hit, bypass_take;
  logic pop_any, fifo_pop, wr_en, drop, issue_acc;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

`ifdef PPU_RESBUF_BYPASS_EN
  assign bypass_hit = empty && ppu_valid_i;
`else
  assign bypass_hit = 1'b0;
`endif

  // Stored data has priority; the live PPU word is only shown when nothing is queued.
  always_comb begin
    out_valid_o = !empty || bypass_hit;
    out_data_o  = '0;
    if (!empty) begin
      out_data_o = mem_q[rptr_q];
    end else if (bypass_hit) begin
      out_data_o = ppu_result_i;
    end
  end

  assign pop_any     = out_valid_o && out_ready_i;
  assign fifo_pop    = pop_any && !empty;
  assign bypass_take = bypass_hit && out_ready_i;
  assign wr_en       = ppu_valid_i && !bypass_take && (!full || fifo_pop);
  assign drop        = ppu_valid_i && full && !fifo_pop;

  assign issue_ready_o = (credit_q != '0);
  assign issue_acc     = issue_valid_i && issue_ready_o;

  assign count_o    = count_q;
  assign overflow_o = overflow_q;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    credit_d   = credit_q;
    overflow_d = overflow_q || drop;

    if (wr_en) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (fifo_pop) begin
      rptr_d = rptr_q + PW'(1);
    end

    case ({wr_en, fifo_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Saturate at DEPTH so a stale result popped after reset cannot mint a credit.
    if (pop_any && !issue_acc) begin
      if (credit_q != DEPTH_C) begin
        credit_d = credit_q + CW'(1);
      end
    end else if (issue_acc && !pop_any) begin
      credit_d = credit_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      credit_q   <= DEPTH_C;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; out_data_o is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wptr_q] <= ppu_result_i;
    end
  end

endmodule

// File: tb/tb_ppu_result_buffer.sv
// Directed bench for ppu_result_buffer: queue-based reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_ppu_result_buffer;

  localparam int WORD  = 32;
  localparam int DEPTH = 4;
`ifdef PPU_RESBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            iv = 1'b0;
  logic            ready;
  logic            pv = 1'b0;
  logic [WORD-1:0] pd = '0;
  logic            ovalid;
  logic [WORD-1:0] odata;
  logic            ordy = 1'b0;
  logic [2:0]      count;
  logic            ovf;

  int checks = 0;
  int failures = 0;

  int unsigned mq[$];
  int unsigned dpop[$];
  int unsigned ex_q[$];
  int          credits = DEPTH;
  bit          movf = 1'b0;

  always #5 clk = ~clk;

  ppu_result_buffer #(.WORD(WORD), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_valid_i(iv), .issue_ready_o(ready),
    .ppu_valid_i(pv), .ppu_result_i(pd),
    .out_valid_o(ovalid), .out_data_o(odata), .out_ready_i(ordy),
    .count_o(count), .overflow_o(ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of results and an integer credit pool.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      credits = DEPTH;
      movf = 1'b0;
    end else begin
      int  sz;
      bit  vis, pop, acc;
      sz  = mq.size();
      vis = (sz != 0) || (BYP && pv);
      pop = vis && ordy;
      acc = iv && (credits != 0);
      if (pop && sz != 0) void'(mq.pop_front());
      if (pv && !(BYP && sz == 0 && ordy)) begin
        if (sz < DEPTH || (pop && sz != 0)) mq.push_back(pd);
        else movf = 1'b1;
      end
      credits = credits + (pop ? 1 : 0) - (acc ? 1 : 0);
      if (credits > DEPTH) credits = DEPTH;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      int unsigned edata;
      bit evalid;
      evalid = (mq.size() != 0) || (BYP && pv);
      edata  = (mq.size() != 0) ? mq[0] : ((BYP && pv) ? pd : 0);
      chk("m_issue_ready", {31'b0, ready}, {31'b0, credits != 0});
      chk("m_out_valid", {31'b0, ovalid}, {31'b0, evalid});
      chk("m_out_data", odata, edata);
      chk("m_count", {29'b0, count}, mq.size());
      chk("m_overflow", {31'b0, ovf}, {31'b0, movf});
      if (ovalid && ordy) dpop.push_back(odata);
    end
  end

  task automatic cycle(input bit i_v, input bit p_v, input int unsigned p_d, input bit o_r);
    iv = i_v; pv = p_v; pd = p_d; ordy = o_r;
    @(posedge clk);
    #1;
    iv = 1'b0; pv = 1'b0; pd = '0; ordy = 1'b0;
  endtask

  task automatic check_pops(input string name);
    chk({name, "_len"}, dpop.size(), ex_q.size());
    for (int k = 0; k < ex_q.size() && k < dpop.size(); k++)
      chk(name, dpop[k], ex_q[k]);
    dpop.delete();
  endtask

  initial begin
    #12;
    chk("rst_ready", {31'b0, ready}, 1);
    chk("rst_valid", {31'b0, ovalid}, 0);
    chk("rst_count", {29'b0, count}, 0);
    chk("rst_ovf", {31'b0, ovf}, 0);
    chk("rst_data", odata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(0, 0, 0, 0);
    chk("idle_ready", {31'b0, ready}, 1);
    chk("idle_count", {29'b0, count}, 0);

    // Credits exhaust, then results fill, then drain in order.
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
    chk("credits_out", {31'b0, ready}, 0);
    cycle(0, 1, 32'h11, 0);
    cycle(0, 1, 32'h22, 0);
    cycle(0, 1, 32'h33, 0);
    cycle(0, 1, 32'h44, 0);
    chk("fill_count", {29'b0, count}, 4);
    chk("fill_head", odata, 32'h11);
    cycle(0, 0, 0, 1);
    chk("ready_after_pop", {31'b0, ready}, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    ex_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    check_pops("drain_order");

    // Write and pop together while full.
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
    cycle(0, 1, 32'h11, 0);
    cycle(0, 1, 32'h22, 0);
    cycle(0, 1, 32'h33, 0);
    cycle(0, 1, 32'h44, 0);
    cycle(0, 1, 32'h55, 1);
    chk("fullwp_count", {29'b0, count}, 4);
    chk("fullwp_ovf", {31'b0, ovf}, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
    ex_q = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    check_pops("fullwp_order");

    // Write into full FIFO without pop: dropped, sticky overflow.
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
    cycle(0, 1, 32'hA1, 0);
    cycle(0, 1, 32'hA2, 0);
    cycle(0, 1, 32'hA3, 0);
    cycle(0, 1, 32'hA4, 0);
    cycle(0, 1, 32'h66, 0);
    chk("drop_count", {29'b0, count}, 4);
    chk("drop_ovf", {31'b0, ovf}, 1);
    cycle(0, 0, 0, 0);
    chk("ovf_held", {31'b0, ovf}, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
    ex_q = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    check_pops("drop_order");
    chk("ovf_after_drain", {31'b0, ovf}, 1);

    // Pointer wrap over ten write/pop pairs.
    for (int i = 1; i <= 10; i++) begin
      cycle(1, 1, i, 0);
      cycle(0, 0, 0, 1);
    end
    ex_q.delete();
    for (int i = 1; i <= 10; i++) ex_q.push_back(i);
    check_pops("wrap_order");

    // Empty FIFO, result with consumer ready.
    iv = 1'b0; pv = 1'b1; pd = 32'hAB; ordy = 1'b1;
    #1;
`ifdef PPU_RESBUF_BYPASS_EN
    chk("byp_valid", {31'b0, ovalid}, 1);
    chk("byp_data", odata, 32'hAB);
`else
    chk("nobyp_valid", {31'b0, ovalid}, 0);
`endif
    @(posedge clk); #1;
    iv = 1'b0; pv = 1'b0; pd = '0; ordy = 1'b0;
`ifdef PPU_RESBUF_BYPASS_EN
    chk("byp_count", {29'b0, count}, 0);
    chk("byp_after_valid", {31'b0, ovalid}, 0);
`else
    chk("nobyp_count", {29'b0, count}, 1);
    chk("nobyp_data", odata, 32'hAB);
    cycle(0, 0, 0, 1);
`endif
    ex_q = '{32'hAB};
    check_pops("byp_pop");

    // Reset in the middle of operation.
    cycle(1, 1, 32'h01, 0);
    cycle(1, 1, 32'h02, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_count", {29'b0, count}, 0);
    chk("midrst_valid", {31'b0, ovalid}, 0);
    chk("midrst_ready", {31'b0, ready}, 1);
    chk("midrst_ovf", {31'b0, ovf}, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(0, 1, 32'h77, 0);
    chk("post_rst_count", {29'b0, count}, 1);
    chk("post_rst_data", odata, 32'h77);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppu_result_buffer.md
# ppu_result_buffer

Downstream companion to the PPU wrapper. It captures every result the PPU emits (`result`/`valid`, no backpressure) into a small FIFO and presents it to the consumer over a ready/valid handshake. It also runs an issue-credit counter so upstream logic never launches more PPU operations than the FIFO can absorb. Placement: PPU output → `ppu_result_buffer` → writeback/consumer; `issue_ready_o` gates PPU issue.

## Interface
- `WORD`, default 32: result width in bits; must match the PPU `WORD`.
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `clk_i`  in  1  clock; all state changes on its rising edge.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `issue_valid_i`  in  1  upstream is launching one PPU operation this cycle.
- `issue_ready_o`  out  1  a credit is available; an issue is accepted when `issue_valid_i && issue_ready_o`.
- `ppu_valid_i`  in  1  PPU result valid (PPU `out_valid_o`).
- `ppu_result_i`  in  WORD  PPU result (PPU `result_o`).
- `out_valid_o`  out  1  head entry valid toward the consumer.
- `out_data_o`  out  WORD  head entry data.
- `out_ready_i`  in  1  consumer accepts; a pop occurs when `out_valid_o && out_ready_i`.
- `count_o`  out  $clog2(DEPTH+1)  current FIFO occupancy.
- `overflow_o`  out  1  sticky: a result arrived while the FIFO was full and no pop occurred.

## Operation
- Storage: `DEPTH` × `WORD` register array with read/write pointers of width $clog2(DEPTH) that wrap modulo `DEPTH`. Occupancy counter has width $clog2(DEPTH+1).
- Write: when `ppu_valid_i` = 1 and (count < DEPTH, or a pop occurs this cycle), write `ppu_result_i` at wptr and advance wptr.
- Full write: when `ppu_valid_i` = 1, count = DEPTH and no pop occurs, drop the result and set `overflow_o` = 1. It stays set until reset.
- Read: `out_valid_o` = (count ≠ 0). `out_data_o` = mem[rptr]. A pop advances rptr.
- Pop with count = 0 is impossible in the base configuration, because `out_valid_o` = 0.
- Occupancy per cycle: +1 on write only, −1 on pop only, unchanged on both or neither.
- Credit counter, width $clog2(DEPTH+1):
  - Resets to DEPTH.
  - −1 on accepted issue only; +1 on pop only; unchanged on both.
  - Saturates at DEPTH, so a stale post-reset result cannot push it above DEPTH.
  - `issue_ready_o` = (credits ≠ 0).
- The credit rule guarantees that in-flight plus stored results never exceed DEPTH, so `overflow_o` signals a protocol violation only.

## Timing
- Reset values while `rst_ni` = 0, applied asynchronously: `out_valid_o`=0, `out_data_o`=0, `count_o`=0, `overflow_o`=0, `issue_ready_o`=1, pointers=0, credits=DEPTH. Memory contents need not be cleared; `out_data_o` is forced to 0 while count = 0.
- Latency, base configuration: result written at edge N, so `out_valid_o` rises after edge N, i.e. 1 cycle.
- `issue_ready_o` is registered-state derived with no combinational path from `issue_valid_i`. It drops the cycle after the last credit is consumed.
- Simultaneous write and pop when full: both take effect; count stays DEPTH; no overflow.
- Reset mid-operation clears all state immediately. Results arriving after reset release are stored normally.

## Configuration
- `PPU_RESBUF_BYPASS_EN` defined: fall-through mode.
  - When count = 0 and `ppu_valid_i` = 1: `out_valid_o` = 1 and `out_data_o` = `ppu_result_i` combinationally.
  - If `out_ready_i` = 1 that cycle, the result is consumed, not written, and credit +1 (0-cycle latency).
  - Otherwise it is written as normal.
- `PPU_RESBUF_BYPASS_EN` undefined: no combinational path from `ppu_*` to `out_*`; latency is always ≥ 1 cycle.

## Test plan
- Reset, then idle: `issue_ready_o`=1, `count_o`=0, `out_valid_o`=0, `overflow_o`=0.
- DEPTH=4: issue 4 ops without popping, giving `issue_ready_o`=0. Then feed results 0x11, 0x22, 0x33, 0x44, giving `count_o`=4. Then pop with `out_ready_i`=1 → data 0x11, 0x22, 0x33, 0x44 in order, and `issue_ready_o`=1 after the first pop.
- Full FIFO with write 0x55 and pop in the same cycle → pop returns 0x11, `count_o` stays 4, `overflow_o`=0, and 0x55 emerges last.
- Full FIFO, write 0x66 with `out_ready_i`=0 → result dropped, `overflow_o`=1 and held; `count_o`=4.
- Pointer wrap: 10 write/pop pairs with values 1…10 → output sequence 1…10 with no gap or duplication.
- Bypass build: empty FIFO, `ppu_valid_i`=1 with 0xAB and `out_ready_i`=1 → `out_valid_o`=1 and `out_data_o`=0xAB in the same cycle, `count_o` stays 0. Non-bypass build: 0xAB appears one cycle later.
